// File: rtl/perimeter_arbiter.sv
// perimeter_arbiter: round-robin arbiter that shares one 2*(a+b) perimeter
// unit among 2**IDW rectangle producers on /dav-rfd input handshakes and
// delivers the tagged result to one consumer over an outgoing /dav-rfd
// handshake.
module perimeter_arbiter #(
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [(2**IDW)*W-1:0]     data_a_in,
  input  logic [(2**IDW)*W-1:0]     data_b_in,
  input  logic [(2**IDW)-1:0]       dav_in_,
  output logic [(2**IDW)-1:0]       rfd_in,
  output logic [W+1:0]              data_out,
  output logic [IDW-1:0]            id_out,
  output logic                      dav_out_,
  input  logic                      rfd_out
);

  localparam int N = 2**IDW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WDAV = 2'd1,
    WRFD = 2'd2,
    WACK = 2'd3
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [N-1:0]     rfd_in_q;
  logic [W+1:0]     data_q;
  logic [IDW-1:0]   id_q;
  logic             dav_out_q;

  logic [N-1:0]     req_s;
  logic             any_req_s;
  logic [IDW-1:0]   win_s;
  logic [IDW-1:0]   idx_s;
  logic             take_s;
  logic [W-1:0]     a_w_s;
  logic [W-1:0]     b_w_s;

  // Exact 2*(a+b): sum widened by one bit, then shifted left by one.
  function automatic logic [W+1:0] perimeter(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return {sum, 1'b0};
  endfunction

  // Round-robin pick: first requesting channel scanning from ptr_q upwards.
  always_comb begin
    req_s     = ~dav_in_ & rfd_in_q;
    any_req_s = 1'b0;
    win_s     = '0;
    idx_s     = '0;
    take_s    = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx_s     = ptr_q + IDW'(i);
      take_s    = req_s[idx_s] & ~any_req_s;
      win_s     = take_s ? idx_s : win_s;
      any_req_s = any_req_s | req_s[idx_s];
    end
  end

  // Operand mux for the winning channel's two sides.
  always_comb begin
    a_w_s = data_a_in[win_s*W +: W];
    b_w_s = data_b_in[win_s*W +: W];
  end

  // Handshake FSM; all outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rfd_in_q  <= '1;
      data_q    <= '0;
      id_q      <= '0;
      dav_out_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          dav_out_q <= 1'b1;
          if (any_req_s) begin
            data_q          <= perimeter(a_w_s, b_w_s);
            id_q            <= win_s;
            rfd_in_q[win_s] <= 1'b0;
            ptr_q           <= win_s + IDW'(1);
            state_q         <= WDAV;
          end else begin
            state_q <= IDLE;
          end
        end
        WDAV: begin
          // Producer must withdraw its request before the channel reopens.
          if (dav_in_[id_q]) begin
            rfd_in_q[id_q] <= 1'b1;
            state_q        <= WRFD;
          end else begin
            state_q <= WDAV;
          end
        end
        WRFD: begin
          if (rfd_out) begin
            dav_out_q <= 1'b0;
            state_q   <= WACK;
          end else begin
            state_q <= WRFD;
          end
        end
        WACK: begin
          if (!rfd_out) begin
            dav_out_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            state_q <= WACK;
          end
        end
        default: begin
          state_q   <= IDLE;
          rfd_in_q  <= '1;
          dav_out_q <= 1'b1;
        end
      endcase
    end
  end

  assign rfd_in   = rfd_in_q;
  assign data_out = data_q;
  assign id_out   = id_q;
  assign dav_out_ = dav_out_q;

endmodule

// File: tb/tb_perimeter_arbiter.sv
// Directed testbench for perimeter_arbiter (W=8, IDW=2, four channels).
module tb_perimeter_arbiter;

  localparam int W   = 8;
  localparam int IDW = 2;
  localparam int N   = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [N*W-1:0]    data_a_in;
  logic [N*W-1:0]    data_b_in;
  logic [N-1:0]      dav_in_;
  logic [N-1:0]      rfd_in;
  logic [W+1:0]      data_out;
  logic [IDW-1:0]    id_out;
  logic              dav_out_;
  logic              rfd_out;

  int total = 0;
  int bad   = 0;

  bit auto_prod = 1'b0;
  bit auto_cons = 1'b0;
  bit cons_hold = 1'b0;
  int cnt [N];
  int got_id[$];
  int got_data[$];

  perimeter_arbiter #(.W(W), .IDW(IDW)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_a_in (data_a_in),
    .data_b_in (data_b_in),
    .dav_in_   (dav_in_),
    .rfd_in    (rfd_in),
    .data_out  (data_out),
    .id_out    (id_out),
    .dav_out_  (dav_out_),
    .rfd_out   (rfd_out)
  );

  always #5 clock = ~clock;

  // Producers: hold dav_in_ low until rfd_in falls, then release; repeat cnt times.
  initial forever begin
    @(posedge clock); #1;
    if (auto_prod) begin
      for (int k = 0; k < N; k++) begin
        if (dav_in_[k] == 1'b0 && rfd_in[k] == 1'b0) begin
          dav_in_[k] = 1'b1;
          cnt[k] = cnt[k] - 1;
        end else if (cnt[k] > 0 && dav_in_[k] == 1'b1 && rfd_in[k] == 1'b1) begin
          dav_in_[k] = 1'b0;
        end
      end
    end
  end

  // Consumer: log each delivered result, acknowledge by dropping rfd_out.
  initial forever begin
    @(posedge clock); #1;
    if (auto_cons) begin
      if (cons_hold) begin
        rfd_out = 1'b0;
      end else if (dav_out_ == 1'b0 && rfd_out == 1'b1) begin
        got_id.push_back(int'(id_out));
        got_data.push_back(int'(data_out));
        rfd_out = 1'b0;
      end else if (dav_out_ == 1'b1 && rfd_out == 1'b0) begin
        rfd_out = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock); #3;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int c;
    c = 0;
    while (got_id.size() < n && c < budget) begin
      tick();
      c++;
    end
  endtask

  task automatic clear_log();
    got_id.delete();
    got_data.delete();
  endtask

  task automatic set_ch(input int k, input int a, input int b);
    data_a_in[k*W +: W] = a[W-1:0];
    data_b_in[k*W +: W] = b[W-1:0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (rfd_in !== 4'b1111) begin bad++; $display("FAIL reset_rfd_in: got %b want 1111", rfd_in); end
    total++; if (dav_out_ !== 1'b1) begin bad++; $display("FAIL reset_dav_out: got %b want 1", dav_out_); end
    total++; if (data_out !== 10'd0) begin bad++; $display("FAIL reset_data_out: got %0d want 0", data_out); end
    total++; if (id_out !== 2'd0) begin bad++; $display("FAIL reset_id_out: got %0d want 0", id_out); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    rfd_out = 1'b1;
    set_ch(2, 10, 20);
    dav_in_[2] = 1'b0;
    tick(); // E0: capture
    total++; if (rfd_in !== 4'b1011) begin bad++; $display("FAIL single_rfd_fall: got %b want 1011", rfd_in); end
    total++; if (dav_out_ !== 1'b1) begin bad++; $display("FAIL single_dav_e0: got %b want 1", dav_out_); end
    total++; if (data_out !== 10'd60) begin bad++; $display("FAIL single_data: got %0d want 60", data_out); end
    total++; if (id_out !== 2'd2) begin bad++; $display("FAIL single_id: got %0d want 2", id_out); end
    dav_in_[2] = 1'b1;
    tick(); // E1
    total++; if (rfd_in !== 4'b1111) begin bad++; $display("FAIL single_rfd_rise: got %b want 1111", rfd_in); end
    total++; if (dav_out_ !== 1'b1) begin bad++; $display("FAIL single_dav_e1: got %b want 1", dav_out_); end
    tick(); // E2
    total++; if (dav_out_ !== 1'b0) begin bad++; $display("FAIL single_dav_e2: got %b want 0", dav_out_); end
    tick(); // E3: consumer still high
    total++; if (dav_out_ !== 1'b0) begin bad++; $display("FAIL single_dav_hold: got %b want 0", dav_out_); end
    rfd_out = 1'b0;
    tick(); // E4
    total++; if (dav_out_ !== 1'b1) begin bad++; $display("FAIL single_dav_ack: got %b want 1", dav_out_); end
    total++; if (data_out !== 10'd60) begin bad++; $display("FAIL single_data_stable: got %0d want 60", data_out); end
    rfd_out = 1'b1;
  endtask

  task automatic test_all_four();
    int exp_id [6];
    int exp_dat [6];
    exp_id  = '{0, 1, 2, 3, 0, 3};
    exp_dat = '{6, 12, 18, 24, 6, 24};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < N; k++) set_ch(k, k + 1, 2 * (k + 1));
    clear_log();
    auto_prod = 1'b1;
    auto_cons = 1'b1;
    for (int k = 0; k < N; k++) cnt[k] = 1;
    wait_outputs(4, 100);
    // Pointer must have wrapped to 0: channel 0 beats channel 3.
    cnt[0] = 1;
    cnt[3] = 1;
    wait_outputs(6, 100);
    total++; if (got_id.size() != 6) begin bad++; $display("FAIL all4_count: got %0d want 6", got_id.size()); end
    for (int k = 0; k < 6; k++) begin
      if (k < got_id.size()) begin
        total++; if (got_id[k] != exp_id[k]) begin bad++; $display("FAIL all4_id[%0d]: got %0d want %0d", k, got_id[k], exp_id[k]); end
        total++; if (got_data[k] != exp_dat[k]) begin bad++; $display("FAIL all4_data[%0d]: got %0d want %0d", k, got_data[k], exp_dat[k]); end
      end
    end
  endtask

  task automatic test_max();
    set_ch(1, 255, 255);
    clear_log();
    cnt[1] = 1;
    wait_outputs(1, 50);
    total++; if (got_id.size() != 1) begin bad++; $display("FAIL max_count: got %0d want 1", got_id.size()); end
    if (got_id.size() > 0) begin
      total++; if (got_data[0] != 1020) begin bad++; $display("FAIL max_data: got %0d want 1020", got_data[0]); end
      total++; if (got_id[0] != 1) begin bad++; $display("FAIL max_id: got %0d want 1", got_id[0]); end
    end
  endtask

  task automatic test_fairness();
    int exp_id [4];
    int exp_dat [4];
    exp_id  = '{3, 0, 3, 3};
    exp_dat = '{24, 4, 24, 24};
    set_ch(3, 5, 7);
    set_ch(0, 1, 1);
    clear_log();
    cnt[3] = 3;
    wait_outputs(1, 50);
    cnt[0] = 1;
    wait_outputs(4, 200);
    total++; if (got_id.size() != 4) begin bad++; $display("FAIL fair_count: got %0d want 4", got_id.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < got_id.size()) begin
        total++; if (got_id[k] != exp_id[k]) begin bad++; $display("FAIL fair_id[%0d]: got %0d want %0d", k, got_id[k], exp_id[k]); end
        total++; if (got_data[k] != exp_dat[k]) begin bad++; $display("FAIL fair_data[%0d]: got %0d want %0d", k, got_data[k], exp_dat[k]); end
      end
    end
  endtask

  task automatic test_hold();
    int dav_low_seen;
    int rfd_drop_seen;
    set_ch(0, 3, 4);
    set_ch(1, 9, 1);
    cons_hold = 1'b1;
    tick();
    clear_log();
    cnt[0] = 1;
    cnt[1] = 1;
    dav_low_seen  = 0;
    rfd_drop_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dav_out_ !== 1'b1) dav_low_seen++;
      if (i >= 5 && rfd_in !== 4'b1111) rfd_drop_seen++;
    end
    total++; if (dav_low_seen != 0) begin bad++; $display("FAIL hold_dav_low_cycles: got %0d want 0", dav_low_seen); end
    total++; if (rfd_drop_seen != 0) begin bad++; $display("FAIL hold_rfd_drop_cycles: got %0d want 0", rfd_drop_seen); end
    total++; if (data_out !== 10'd14) begin bad++; $display("FAIL hold_data: got %0d want 14", data_out); end
    total++; if (id_out !== 2'd0) begin bad++; $display("FAIL hold_id: got %0d want 0", id_out); end
    total++; if (dav_in_[1] !== 1'b0) begin bad++; $display("FAIL hold_ch1_pending: got %b want 0", dav_in_[1]); end
    cons_hold = 1'b0;
    wait_outputs(2, 100);
    total++; if (got_id.size() != 2) begin bad++; $display("FAIL hold_count: got %0d want 2", got_id.size()); end
    if (got_id.size() == 2) begin
      total++; if (got_id[0] != 0 || got_id[1] != 1) begin bad++; $display("FAIL hold_ids: got %0d,%0d want 0,1", got_id[0], got_id[1]); end
      total++; if (got_data[0] != 14 || got_data[1] != 20) begin bad++; $display("FAIL hold_data_seq: got %0d,%0d want 14,20", got_data[0], got_data[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    // Reset while the consumer is mid-ack (WACK with rfd_out still high).
    auto_cons = 1'b0;
    rfd_out = 1'b1;
    clear_log();
    cnt[2] = 1;
    c = 0;
    while (dav_out_ !== 1'b0 && c < 30) begin tick(); c++; end
    total++; if (dav_out_ !== 1'b0) begin bad++; $display("FAIL wack_reach: got %b want 0", dav_out_); end
    reset = 1'b1;
    tick();
    total++; if (rfd_in !== 4'b1111) begin bad++; $display("FAIL wack_rst_rfd: got %b want 1111", rfd_in); end
    total++; if (dav_out_ !== 1'b1) begin bad++; $display("FAIL wack_rst_dav: got %b want 1", dav_out_); end
    total++; if (data_out !== 10'd0) begin bad++; $display("FAIL wack_rst_data: got %0d want 0", data_out); end
    total++; if (id_out !== 2'd0) begin bad++; $display("FAIL wack_rst_id: got %0d want 0", id_out); end
    reset = 1'b0;
    // Reset while waiting for the producer to release (WDAV).
    auto_prod = 1'b0;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    dav_in_ = 4'b1111;
    tick();
    dav_in_[1] = 1'b0;
    tick();
    total++; if (rfd_in !== 4'b1101) begin bad++; $display("FAIL wdav_reach: got %b want 1101", rfd_in); end
    reset = 1'b1;
    dav_in_[1] = 1'b1;
    tick();
    total++; if (rfd_in !== 4'b1111) begin bad++; $display("FAIL wdav_rst_rfd: got %b want 1111", rfd_in); end
    total++; if (dav_out_ !== 1'b1) begin bad++; $display("FAIL wdav_rst_dav: got %b want 1", dav_out_); end
    total++; if (data_out !== 10'd0) begin bad++; $display("FAIL wdav_rst_data: got %0d want 0", data_out); end
    total++; if (id_out !== 2'd0) begin bad++; $display("FAIL wdav_rst_id: got %0d want 0", id_out); end
    reset = 1'b0;
    tick();
    tick();
    tick();
    total++; if (dav_out_ !== 1'b1) begin bad++; $display("FAIL wdav_no_emit: got %b want 1", dav_out_); end
    // Pointer restarts at 0: channel 0 wins over channel 3.
    clear_log();
    auto_prod = 1'b1;
    auto_cons = 1'b1;
    cnt[0] = 1;
    cnt[3] = 1;
    wait_outputs(2, 100);
    total++; if (got_id.size() != 2) begin bad++; $display("FAIL ptr_rst_count: got %0d want 2", got_id.size()); end
    if (got_id.size() == 2) begin
      total++; if (got_id[0] != 0 || got_id[1] != 3) begin bad++; $display("FAIL ptr_rst_order: got %0d,%0d want 0,3", got_id[0], got_id[1]); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    data_a_in = '0;
    data_b_in = '0;
    dav_in_   = 4'b1111;
    rfd_out   = 1'b1;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    test_reset();
    test_single();
    test_all_four();
    test_max();
    test_fairness();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
